uart_receiver: RTL

Serial-to-parallel UART receiver that consumes the oversampled `Rx_clk` tick from the baud rate generator and recovers 8N1 frames (optionally 8E1) from the asynchronous `rx_serial` line. It sits between the pad-side serial input and the receive-side host logic. It presents each recovered byte with a one-cycle valid pulse and frame/parity error flags.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync2.sv | 20 ++
 rtl/uart_receiver.sv | 102 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and defaults
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
    localparam int OVERSAMBLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;
    localparam logic UART_IDLE    = 1'b1;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer with configurable reset value
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk) begin
        if (!rst) begin
            m <= RST_VAL;
            q <= RST_VAL;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver
// Define UART_RX_PARITY_EN to expect an even-parity bit after the payload.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMBLE = OVERSAMBLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_clk,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMBLE);
    localparam int IW = $clog2(DATA_BITS);
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s, rx_d, fall, mid, full;
`ifdef UART_RX_PARITY_EN
    logic                 par;
`else
    assign parity_err = 1'b0;
`endif
    uart_sync2 #(.RST_VAL(UART_IDLE)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(rx_serial),
        .q(rx_s)
    );
    assign fall = rx_d & ~rx_s;
    assign mid  = Rx_clk && cnt == CW'(OVERSAMBLE / 2 - 1);
    assign full = Rx_clk && cnt == CW'(OVERSAMBLE - 1);
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_d      <= UART_IDLE;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par        <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_d      <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (Rx_clk && state != IDLE) cnt <= cnt + 1'b1;
            case (state)
                IDLE: if (fall) begin
                    state <= START;
                    cnt   <= '0;
                end
                START: if (mid) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rx_s ? IDLE : DATA;
                end
                DATA: if (full) begin
                    shift <= {rx_s, shift[DATA_BITS-1:1]};
                    idx   <= idx + 1'b1;
                    cnt   <= '0;
`ifdef UART_RX_PARITY_EN
                    if (idx == IW'(DATA_BITS - 1)) state <= PARITY;
                end
                PARITY: if (full) begin
                    par   <= ^shift ^ rx_s;
                    cnt   <= '0;
                    state <= STOP;
`else
                    if (idx == IW'(DATA_BITS - 1)) state <= STOP;
`endif
                end
                STOP: if (full) begin
                    rx_data   <= shift;
                    rx_valid  <= 1'b1;
                    frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err <= par;
`endif
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
